// File: rtl/code_lock_ctrl.sv
// Purpose: 4-digit combination-lock controller between the rotary encoder and the seven-seg driver.
// Latency: every output is registered and reflects a press or timeout one cycle after it is sampled.
// Backpressure: none; press pulses are consumed in the cycle they are high. Build option CODE_CHANGE_EN adds the SET state.
module code_lock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int          OPEN_CYCLES    = 50000,
    parameter int          LOCKOUT_CYCLES = 100000,
    parameter int          ERROR_CYCLES   = 10000,
    parameter int          MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] enc,
    input  logic [2:0] pb_press_type,
    output logic [3:0] display_value,
    output logic [2:0] display_select,
    output logic       unlocked,
    output logic       alarm,
    output logic [2:0] fail_cnt
);

    localparam int TMAX_A = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > ERROR_CYCLES) ? TMAX_A : ERROR_CYCLES;
    localparam int TW     = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] ERROR_LAST = TW'(ERROR_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_ERROR,
`ifdef CODE_CHANGE_EN
        S_SET,
`endif
        S_LOCKOUT
    } state_t;

    state_t        state_q, state_nxt;
    logic [1:0]    idx_q, idx_nxt;
    logic [15:0]   entry_buf_q, entry_buf_nxt;
    logic [TW-1:0] timer_q, timer_nxt;
    logic [2:0]    fail_nxt;
    logic [2:0]    fail_inc;
    logic [15:0]   code_q;
    logic [3:0]    val_nxt;
    logic [2:0]    sel_nxt;
    logic          unl_nxt;
    logic          alarm_nxt;

    // A press counts only when exactly one type bit is set.
    logic press_short, press_long;
    assign press_short = (pb_press_type == 3'b001);
    assign press_long  = (pb_press_type == 3'b010);

`ifdef CODE_CHANGE_EN
    logic        press_dbl;
    logic [15:0] code_nxt;
    assign press_dbl = (pb_press_type == 3'b100);
`else
    assign code_q = DEFAULT_CODE;
`endif

    // Digit 0 sits in the top nibble so the code reads left-to-right as hex.
    function automatic logic [15:0] put_digit(input logic [15:0] b, input logic [1:0] i,
                                              input logic [3:0] d);
        logic [15:0] r;
        r = b;
        case (i)
            2'd0:    r[15:12] = d;
            2'd1:    r[11:8]  = d;
            2'd2:    r[7:4]   = d;
            default: r[3:0]   = d;
        endcase
        return r;
    endfunction

    // Next-state, entry buffer, fail count and stored-code updates.
    always_comb begin
        state_nxt     = state_q;
        idx_nxt       = idx_q;
        entry_buf_nxt = entry_buf_q;
        fail_nxt      = fail_cnt;
        fail_inc      = fail_cnt + 3'd1;
`ifdef CODE_CHANGE_EN
        code_nxt      = code_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press_short) begin
                    entry_buf_nxt = put_digit(16'h0000, 2'd0, enc);
                    idx_nxt       = 2'd1;
                    state_nxt     = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (press_long) begin
                    state_nxt = S_IDLE;
                end else if (press_short) begin
                    entry_buf_nxt = put_digit(entry_buf_q, idx_q, enc);
                    idx_nxt       = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (entry_buf_q == code_q) begin
                    fail_nxt  = 3'd0;
                    state_nxt = S_OPEN;
                end else begin
                    // Lockout triggers on reaching the limit, so the count never exceeds it.
                    fail_nxt  = fail_inc;
                    state_nxt = (fail_inc == FAIL_LIMIT) ? S_LOCKOUT : S_ERROR;
                end
            end
            S_OPEN: begin
                if (timer_q == OPEN_LAST || press_long) begin
                    state_nxt = S_IDLE;
`ifdef CODE_CHANGE_EN
                end else if (press_dbl) begin
                    idx_nxt       = 2'd0;
                    entry_buf_nxt = 16'h0000;
                    state_nxt     = S_SET;
`endif
                end
            end
            S_ERROR: begin
                if (timer_q == ERROR_LAST) state_nxt = S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    fail_nxt  = 3'd0;
                    state_nxt = S_IDLE;
                end
            end
`ifdef CODE_CHANGE_EN
            S_SET: begin
                if (press_long) begin
                    state_nxt = S_IDLE;
                end else if (press_short) begin
                    entry_buf_nxt = put_digit(entry_buf_q, idx_q, enc);
                    idx_nxt       = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        code_nxt  = put_digit(entry_buf_q, idx_q, enc);
                        state_nxt = S_IDLE;
                    end
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_IDLE) begin
            entry_buf_nxt = 16'h0000;
            idx_nxt       = 2'd0;
        end

        // Timer restarts on every state change and only runs in the timed states.
        if (state_nxt != state_q) begin
            timer_nxt = '0;
        end else if (state_q == S_OPEN || state_q == S_ERROR || state_q == S_LOCKOUT) begin
            timer_nxt = timer_q + 1'b1;
        end else begin
            timer_nxt = '0;
        end
    end

    // Output values are decoded from the next state so they land one cycle after the cause.
    always_comb begin
        val_nxt   = enc;
        sel_nxt   = {1'b0, idx_nxt};
        unl_nxt   = 1'b0;
        alarm_nxt = 1'b0;
        case (state_nxt)
            S_OPEN: begin
                val_nxt = 4'hA;
                sel_nxt = 3'b100;
                unl_nxt = 1'b1;
            end
            S_ERROR: begin
                val_nxt = 4'hE;
                sel_nxt = 3'b100;
            end
            S_LOCKOUT: begin
                val_nxt   = 4'hF;
                sel_nxt   = 3'b100;
                alarm_nxt = 1'b1;
            end
`ifdef CODE_CHANGE_EN
            S_SET: unl_nxt = 1'b1;
`endif
            default: ;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            idx_q          <= 2'd0;
            entry_buf_q    <= 16'h0000;
            timer_q        <= '0;
            fail_cnt       <= 3'd0;
            display_value  <= 4'h0;
            display_select <= 3'b000;
            unlocked       <= 1'b0;
            alarm          <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            idx_q          <= idx_nxt;
            entry_buf_q    <= entry_buf_nxt;
            timer_q        <= timer_nxt;
            fail_cnt       <= fail_nxt;
            display_value  <= val_nxt;
            display_select <= sel_nxt;
            unlocked       <= unl_nxt;
            alarm          <= alarm_nxt;
        end
    end

`ifdef CODE_CHANGE_EN
    // Stored code; reverts to the default on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) code_q <= DEFAULT_CODE;
        else       code_q <= code_nxt;
    end
`endif

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Purpose: self-checking bench for code_lock_ctrl using short timer parameters.
// Latency: checks every cycle 1 time unit after the rising edge.
// Backpressure: none.
module tb_code_lock_ctrl;

    localparam int OPEN_C = 20;
    localparam int LOCK_C = 30;
    localparam int ERR_C  = 10;
    localparam int MAXF   = 3;

    localparam logic [2:0] P_NONE  = 3'b000;
    localparam logic [2:0] P_SHORT = 3'b001;
    localparam logic [2:0] P_LONG  = 3'b010;
    localparam logic [2:0] P_DBL   = 3'b100;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] enc = 4'h0;
    logic [2:0] pb_press_type = 3'b000;
    logic [3:0] display_value;
    logic [2:0] display_select;
    logic       unlocked;
    logic       alarm;
    logic [2:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    code_lock_ctrl #(
        .DEFAULT_CODE  (16'h1234),
        .OPEN_CYCLES   (OPEN_C),
        .LOCKOUT_CYCLES(LOCK_C),
        .ERROR_CYCLES  (ERR_C),
        .MAX_FAILS     (MAXF)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enc           (enc),
        .pb_press_type (pb_press_type),
        .display_value (display_value),
        .display_select(display_select),
        .unlocked      (unlocked),
        .alarm         (alarm),
        .fail_cnt      (fail_cnt)
    );

    // Reference model: digits typed so far, countdowns for the timed phases.
    logic [3:0]  q[$];
    logic [3:0]  sq[$];
    bit          checking, setting;
    int          open_left, err_left, lock_left, fails;
    logic [15:0] code;
    logic [3:0]  e_val;
    logic [2:0]  e_sel;
    logic        e_unl, e_alarm;
    logic [2:0]  e_fail;
    bit          e_dc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        sq.delete();
        checking = 0; setting = 0;
        open_left = 0; err_left = 0; lock_left = 0; fails = 0;
        code = 16'h1234;
        e_val = 0; e_sel = 0; e_unl = 0; e_alarm = 0; e_fail = 0; e_dc = 0;
    endtask

    task automatic model_step(input logic [3:0] e, input logic [2:0] p);
        bit s, l;
        s = (p == P_SHORT);
        l = (p == P_LONG);
        if (checking) begin
            checking = 0;
            if ({q[0], q[1], q[2], q[3]} == code) begin
                open_left = OPEN_C;
                fails = 0;
            end else begin
                fails++;
                if (fails == MAXF) lock_left = LOCK_C;
                else err_left = ERR_C;
            end
            q.delete();
        end else if (open_left > 0) begin
            if (open_left == 1 || l) open_left = 0;
`ifdef CODE_CHANGE_EN
            else if (p == P_DBL) begin open_left = 0; setting = 1; sq.delete(); end
`endif
            else open_left--;
        end else if (err_left > 0) begin
            err_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (setting) begin
            if (l) begin
                setting = 0; sq.delete();
            end else if (s) begin
                sq.push_back(e);
                if (sq.size() == 4) begin
                    code = {sq[0], sq[1], sq[2], sq[3]};
                    setting = 0; sq.delete();
                end
            end
        end else begin
            if (l) q.delete();
            else if (s) begin
                q.push_back(e);
                if (q.size() == 4) checking = 1;
            end
        end
        e_dc = checking; e_unl = 0; e_alarm = 0; e_val = e; e_sel = 3'b000;
        if (open_left > 0) begin e_val = 4'hA; e_sel = 3'b100; e_unl = 1; end
        else if (err_left > 0) begin e_val = 4'hE; e_sel = 3'b100; end
        else if (lock_left > 0) begin e_val = 4'hF; e_sel = 3'b100; e_alarm = 1; end
        else if (setting) begin e_sel = 3'(sq.size()); e_unl = 1; end
        else if (!checking) e_sel = 3'(q.size());
        e_fail = 3'(fails);
    endtask

    task automatic check_model();
        if (!e_dc) begin
            chk("m_val", 16'(display_value), 16'(e_val));
            chk("m_sel", 16'(display_select), 16'(e_sel));
        end
        chk("m_unl", 16'(unlocked), 16'(e_unl));
        chk("m_alarm", 16'(alarm), 16'(e_alarm));
        chk("m_fail", 16'(fail_cnt), 16'(e_fail));
    endtask

    task automatic tick(input logic [3:0] e, input logic [2:0] p);
        enc = e;
        pb_press_type = p;
        @(posedge clk);
        model_step(e, p);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        pb_press_type = P_NONE;
        #3;
        model_reset();
        chk("rst_val", 16'(display_value), 16'h0);
        chk("rst_sel", 16'(display_select), 16'h0);
        chk("rst_unl", 16'(unlocked), 16'h0);
        chk("rst_alarm", 16'(alarm), 16'h0);
        chk("rst_fail", 16'(fail_cnt), 16'h0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic enter(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        for (int i = 0; i < 4; i++) begin
            tick(v[15:12], P_SHORT);
            v = v << 4;
        end
    endtask

    task automatic wrong_attempt();
        enter(16'h1235);
        tick(4'h0, P_NONE);
        for (int i = 0; i < ERR_C; i++) tick(4'h0, P_NONE);
    endtask

    typedef struct {
        logic [3:0] enc;
        logic [2:0] press;
        logic [3:0] val;
        logic [2:0] sel;
        logic       unl;
        logic       alm;
        logic [2:0] fail;
        bit         dc;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int cnt;
        int r;
        logic [3:0] e;
        logic [2:0] p;
        logic [2:0] ill[4];

        tbl[0]  = '{4'h1, P_NONE,  4'h1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{4'h1, P_SHORT, 4'h1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{4'h6, P_NONE,  4'h6, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{4'h2, P_SHORT, 4'h2, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[4]  = '{4'h9, 3'b011,  4'h9, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{4'h3, P_SHORT, 4'h3, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{4'h5, P_DBL,   4'h5, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{4'h4, P_SHORT, 4'h0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1};
        tbl[8]  = '{4'h0, P_NONE,  4'hA, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{4'h7, P_SHORT, 4'hA, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[10] = '{4'h7, P_LONG,  4'h7, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[11] = '{4'h1, P_SHORT, 4'h1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[12] = '{4'h2, P_SHORT, 4'h2, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[13] = '{4'h3, P_SHORT, 4'h3, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{4'h5, P_SHORT, 4'h0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1};
        tbl[15] = '{4'h0, P_NONE,  4'hE, 3'd4, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[16] = '{4'h0, P_NONE,  4'hE, 3'd4, 1'b0, 1'b0, 3'd1, 1'b0};
        ill[0] = 3'b011; ill[1] = 3'b101; ill[2] = 3'b110; ill[3] = 3'b111;

        // Table-driven opening sequence.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].enc, tbl[i].press);
            if (!tbl[i].dc) begin
                chk($sformatf("tbl%0d_val", i), 16'(display_value), 16'(tbl[i].val));
                chk($sformatf("tbl%0d_sel", i), 16'(display_select), 16'(tbl[i].sel));
            end
            chk($sformatf("tbl%0d_unl", i), 16'(unlocked), 16'(tbl[i].unl));
            chk($sformatf("tbl%0d_alarm", i), 16'(alarm), 16'(tbl[i].alm));
            chk($sformatf("tbl%0d_fail", i), 16'(fail_cnt), 16'(tbl[i].fail));
        end

        // Correct code: unlocked two cycles after the 4th press, held exactly OPEN_C cycles.
        do_reset();
        enter(16'h1234);
        chk("t1_unl_check_cycle", 16'(unlocked), 16'h0);
        tick(4'h0, P_NONE);
        chk("t1_unl_2cyc", 16'(unlocked), 16'h1);
        chk("t1_val_A", 16'(display_value), 16'hA);
        cnt = 1;
        for (int i = 0; i < OPEN_C + 5 && unlocked; i++) begin
            tick(4'h0, P_NONE);
            if (unlocked) cnt++;
        end
        chk("t1_open_len", 16'(cnt), 16'(OPEN_C));

        // Wrong code, then a press landing on the ERROR timeout cycle is dropped.
        do_reset();
        enter(16'h1235);
        tick(4'h0, P_NONE);
        chk("t2_val_E", 16'(display_value), 16'hE);
        chk("t2_fail1", 16'(fail_cnt), 16'h1);
        for (int i = 0; i < ERR_C - 1; i++) tick(4'h0, P_NONE);
        chk("t2_still_err", 16'(display_value), 16'hE);
        tick(4'h5, P_SHORT);
        chk("t2_drop_sel", 16'(display_select), 16'h0);
        chk("t2_drop_val", 16'(display_value), 16'h5);

        // Two more failures reach the lockout; presses ignored while locked.
        wrong_attempt();
        chk("t3_fail2", 16'(fail_cnt), 16'h2);
        enter(16'h4321);
        tick(4'h0, P_NONE);
        chk("t3_alarm", 16'(alarm), 16'h1);
        chk("t3_fail3", 16'(fail_cnt), 16'h3);
        cnt = 1;
        for (int i = 0; i < LOCK_C + 5 && alarm; i++) begin
            tick(4'(i), (i % 3 == 0) ? P_SHORT : ((i % 3 == 1) ? P_LONG : P_DBL));
            if (alarm) cnt++;
        end
        chk("t3_lock_len", 16'(cnt), 16'(LOCK_C));
        chk("t3_fail_clr", 16'(fail_cnt), 16'h0);

        // Long press aborts entry and truly clears the buffer.
        do_reset();
        tick(4'h1, P_SHORT);
        tick(4'h2, P_SHORT);
        tick(4'h9, P_LONG);
        chk("t4_idx0", 16'(display_select), 16'h0);
        enter(16'h1234);
        tick(4'h0, P_NONE);
        chk("t4_open", 16'(unlocked), 16'h1);

        // Asynchronous reset mid-OPEN clears everything without a clock edge.
        for (int i = 0; i < 5; i++) tick(4'h0, P_NONE);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_async_unl", 16'(unlocked), 16'h0);
        chk("t5_async_val", 16'(display_value), 16'h0);
        chk("t5_async_sel", 16'(display_select), 16'h0);
        model_reset();
        #8;
        rstn = 1'b1;
        tick(4'h3, P_NONE);
        chk("t5_idle_val", 16'(display_value), 16'h3);
        tick(4'h3, P_SHORT);
        chk("t5_idle_entry", 16'(display_select), 16'h1);

`ifdef CODE_CHANGE_EN
        // Code change: new code 9876 replaces 1234.
        do_reset();
        enter(16'h1234);
        tick(4'h0, P_NONE);
        tick(4'h0, P_DBL);
        chk("t6_set_unl", 16'(unlocked), 16'h1);
        chk("t6_set_sel", 16'(display_select), 16'h0);
        enter(16'h9876);
        chk("t6_idle", 16'(unlocked), 16'h0);
        enter(16'h1234);
        tick(4'h0, P_NONE);
        chk("t6_old_err", 16'(display_value), 16'hE);
        for (int i = 0; i < ERR_C; i++) tick(4'h0, P_NONE);
        enter(16'h9876);
        tick(4'h0, P_NONE);
        chk("t6_new_open", 16'(unlocked), 16'h1);
`endif

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) p = P_NONE;
            else if (r < 80) p = P_SHORT;
            else if (r < 84) p = P_LONG;
            else if (r < 90) p = P_DBL;
            else p = ill[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1 && q.size() < 4) begin
                case (q.size())
                    0: e = code[15:12];
                    1: e = code[11:8];
                    2: e = code[7:4];
                    default: e = code[3:0];
                endcase
            end else begin
                e = 4'($urandom_range(0, 15));
            end
            tick(e, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
